// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at the start edge and held in a pending register until the busy window ends.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic [2*WIDTH-1:0]      a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0]      prod_s, prod_u;
    logic signed [WIDTH-1:0] a_s, b_div_s, quo_s, rem_s;
    logic [WIDTH-1:0]        b_div_u, quo_u, rem_u;
    logic                    div_zero, div_ovf;

    assign a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign a_zx   = {{WIDTH{1'b0}}, src_a};
    assign b_zx   = {{WIDTH{1'b0}}, src_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // MIN / -1 is steered to MIN / 1, which yields the wrapped quotient and a zero remainder.
    assign div_zero = (src_b == '0);
    assign div_ovf  = (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
    assign a_s      = src_a;
    assign b_div_s  = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : src_b;
    assign quo_s    = a_s / b_div_s;
    assign rem_s    = a_s % b_div_s;
    assign b_div_u  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : src_b;
    assign quo_u    = src_a / b_div_u;
    assign rem_u    = src_a % b_div_u;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0: begin
                            pend_hi_d = prod_s[2*WIDTH-1:WIDTH];
                            pend_lo_d = prod_s[WIDTH-1:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = RUN;
                        end
                        3'd1: begin
                            pend_hi_d = prod_u[2*WIDTH-1:WIDTH];
                            pend_lo_d = prod_u[WIDTH-1:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = RUN;
                        end
                        3'd2: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quo_s;
                            pend_wr_d = !div_zero;
                            cnt_d     = DIV_LOAD;
                            state_d   = RUN;
                        end
                        3'd3: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quo_u;
                            pend_wr_d = !div_zero;
                            cnt_d     = DIV_LOAD;
                            state_d   = RUN;
                        end
                        3'd4:    hi_d = src_a;
                        3'd5:    lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected busy windows and HI/LO results,
// a negedge monitor checks every cycle against the front of the queue.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          e;
        int          n;
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } item_t;

    item_t       q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;
    logic [31:0] cur_hi   = '0;
    logic [31:0] cur_lo   = '0;
    bit          mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: new {hi,lo} and busy length for one op applied to current HI/LO.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ch, input logic [31:0] cl,
                                  output logic [31:0] nh, output logic [31:0] nl, output int n);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        nh = ch;
        nl = cl;
        n  = 0;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                p  = longint'(sa) * longint'(sb);
                nh = p[63:32];
                nl = p[31:0];
                n  = 5;
            end
            3'd1: begin
                pu = {32'h0, a} * {32'h0, b};
                nh = pu[63:32];
                nl = pu[31:0];
                n  = 5;
            end
            3'd2: begin
                n = 10;
                if (b != 32'h0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        nl = a;
                        nh = 32'h0;
                    end else begin
                        nl = sa / sb;
                        nh = sa % sb;
                    end
                end
            end
            3'd3: begin
                n = 10;
                if (b != 32'h0) begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            3'd4:    nh = a;
            3'd5:    nl = a;
            default: ;
        endcase
    endfunction

    // Issue one op; optionally inject a start (inj_op/inj_a) or a reset at a given busy-cycle offset.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_off, input logic [2:0] inj_op, input logic [31:0] inj_a,
                         input int rst_off);
        logic [31:0] nh, nl;
        int          n, e, due;
        item_t       it;
        model(op, a, b, m_hi, m_lo, nh, nl, n);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        e     = cyc;
        start = 1'b0;
        md_op = 3'($urandom_range(0, 7));
        src_a = $urandom;
        src_b = $urandom;
        due   = e + n;
        it    = '{e, n, due, nh, nl};
        q.push_back(it);
        m_hi = nh;
        m_lo = nl;
        while (cyc < due) begin
            if (cyc == e + inj_off) begin
                start = 1'b1;
                md_op = inj_op;
                src_a = inj_a;
            end
            if (cyc == e + rst_off) begin
                reset = 1'b1;
                due   = e + rst_off + 1;
                it    = '{e, rst_off + 1, due, 32'h0, 32'h0};
                q[q.size()-1] = it;
                m_hi = '0;
                m_lo = '0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            reset = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit exp_b;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q.size() > 0 && cyc == q[0].due) begin
                    chk("done_hi", hi, q[0].hi);
                    chk("done_lo", lo, q[0].lo);
                    chk("done_busy", 32'(busy), 32'h0);
                    cur_hi = q[0].hi;
                    cur_lo = q[0].lo;
                    void'(q.pop_front());
                end else begin
                    exp_b = (q.size() > 0) && (q[0].n > 0) && (cyc >= q[0].e) && (cyc < q[0].e + q[0].n);
                    chk("busy", 32'(busy), 32'(exp_b));
                    chk("hold_hi", hi, cur_hi);
                    chk("hold_lo", lo, cur_lo);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        item_t       it;
        logic [2:0]  op;
        int          inj, rst, idle_at;
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        src_a = '0;
        src_b = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        it = '{cyc, 0, cyc, 32'h0, 32'h0};
        q.push_back(it);
        mon_en = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, 3'd0, 32'h0, -1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1, 3'd0, 32'h0, -1);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0, 32'h0, -1);
        do_op(3'd5, 32'h0000_1234, 32'h0, -1, 3'd0, 32'h0, -1);
        do_op(3'd4, 32'h0000_5678, 32'h0, -1, 3'd0, 32'h0, -1);
        do_op(3'd3, 32'd9, 32'd0, -1, 3'd0, 32'h0, -1);
        do_op(3'd2, 32'd100, 32'd7, 2, 3'd5, 32'h0000_DEAD, -1);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0, 32'h0, -1);
        do_op(3'd2, 32'd1000, 32'd3, -1, 3'd0, 32'h0, 3);

        idle_at = cyc + 12;
        it = '{idle_at, 0, idle_at, 32'h0, 32'h0};
        q.push_back(it);
        while (cyc < idle_at) begin
            @(posedge clk);
            #1;
        end

        repeat (60) begin
            op  = 3'($urandom_range(0, 7));
            inj = -1;
            rst = -1;
            if (op <= 3'd3 && $urandom_range(0, 3) == 0) inj = $urandom_range(0, 3);
            if (op <= 3'd3 && $urandom_range(0, 9) == 0) rst = $urandom_range(0, 4);
            do_op(op, pick(), pick(), inj, 3'($urandom_range(0, 7)), $urandom, rst);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
